// File: rtl/kmeans_pkg.sv
// rtl/kmeans_pkg.sv - shared k-means widths, centroid type and convergence FSM states
package kmeans_pkg;

    localparam int CORD_WIDTH = 13;
    localparam int CORD_NUM   = 7;
    localparam int CENT_NUM   = 8;
    localparam int DATA_WIDTH = CORD_NUM * CORD_WIDTH;
    localparam int IDX_WIDTH  = 3;

    typedef logic [DATA_WIDTH-1:0] centroid_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

endpackage

// File: rtl/centroid_distance_cmp.sv
// rtl/centroid_distance_cmp.sv - flags a centroid whose coordinates moved beyond the threshold
module centroid_distance_cmp
    import kmeans_pkg::*;
(
    input  centroid_t             old_centroid,
    input  centroid_t             new_centroid,
    input  logic [CORD_WIDTH-1:0] threshold,
    output logic                  moved
);

    logic [CORD_NUM-1:0] over;

    for (genvar k = 0; k < CORD_NUM; k++) begin : g_coord
        logic [CORD_WIDTH-1:0] old_c;
        logic [CORD_WIDTH-1:0] new_c;
        logic [CORD_WIDTH-1:0] mag;

        assign old_c   = old_centroid[k*CORD_WIDTH +: CORD_WIDTH];
        assign new_c   = new_centroid[k*CORD_WIDTH +: CORD_WIDTH];
        // Subtracting the smaller from the larger keeps the magnitude within 13 bits.
        assign mag     = (old_c > new_c) ? (old_c - new_c) : (new_c - old_c);
        assign over[k] = (mag > threshold);
    end

    assign moved = |over;

endmodule

// File: rtl/convergence_check_block.sv
// rtl/convergence_check_block.sv - collects new centroids, updates the bank and reports convergence
module convergence_check_block
    import kmeans_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_iter,
    input  logic [CORD_WIDTH-1:0] threshold,
    input  logic                  init_load,
    input  logic [IDX_WIDTH-1:0]  init_idx,
    input  centroid_t             init_centroid,
    input  logic                  new_valid,
    input  centroid_t             new_centroid,
    input  logic [IDX_WIDTH-1:0]  cent_cnt_nxt_block,
    input  logic                  divide_by_0,
    input  logic [IDX_WIDTH-1:0]  rd_idx,
    output centroid_t             rd_centroid,
    output logic                  iter_done,
    output logic                  converged,
    output logic [CENT_NUM-1:0]   empty_mask,
    output logic                  dup_error
);

    centroid_t             bank [CENT_NUM];
    state_t                state;
    state_t                state_nxt;
    logic [CENT_NUM-1:0]   rx_mask;
    logic [CENT_NUM-1:0]   idx_bit;
    logic                  moved_q;
    logic [CORD_WIDTH-1:0] thr_q;
    centroid_t             old_centroid;
    logic                  beat;
    logic                  beat_moved;
    logic                  beat_last;

    assign rd_centroid  = bank[rd_idx];
    assign old_centroid = bank[cent_cnt_nxt_block];
    assign idx_bit      = CENT_NUM'(1) << cent_cnt_nxt_block;
    // A restart in the same cycle as a beat discards the beat.
    assign beat         = (state == COLLECT) && new_valid && !start_iter;
    assign beat_last    = beat && (&(rx_mask | idx_bit));

    centroid_distance_cmp u_cmp (
        .old_centroid (old_centroid),
        .new_centroid (new_centroid),
        .threshold    (thr_q),
        .moved        (beat_moved)
    );

    always_comb begin
        state_nxt = state;
        iter_done = 1'b0;
        case (state)
            IDLE:    if (start_iter) state_nxt = COLLECT;
            COLLECT: if (beat_last) state_nxt = DONE;
            DONE: begin
                iter_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rx_mask    <= '0;
            moved_q    <= 1'b0;
            thr_q      <= '0;
            empty_mask <= '0;
            dup_error  <= 1'b0;
            converged  <= 1'b0;
            for (int i = 0; i < CENT_NUM; i++) begin
                bank[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (start_iter && (state != DONE)) begin
                rx_mask    <= '0;
                moved_q    <= 1'b0;
                empty_mask <= '0;
                dup_error  <= 1'b0;
                converged  <= 1'b0;
                thr_q      <= threshold;
            end else if (beat) begin
                rx_mask <= rx_mask | idx_bit;
                if (rx_mask[cent_cnt_nxt_block]) begin
                    dup_error <= 1'b1;
                end
                if (divide_by_0) begin
                    empty_mask[cent_cnt_nxt_block] <= 1'b1;
                end else begin
                    moved_q                  <= moved_q | beat_moved;
                    bank[cent_cnt_nxt_block] <= new_centroid;
                end
                // Resolve the verdict on the completing beat so it is valid alongside iter_done.
                if (beat_last) begin
                    converged <= !(moved_q || (beat_moved && !divide_by_0));
                end
            end
            if ((state == IDLE) && init_load) begin
                bank[init_idx] <= init_centroid;
            end
        end
    end

endmodule

// File: tb/tb_convergence_check_block.sv
// tb/tb_convergence_check_block.sv - randomized self-checking bench for convergence_check_block
module tb_convergence_check_block;
    import kmeans_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_iter = 1'b0;
    logic [12:0] threshold = '0;
    logic        init_load = 1'b0;
    logic [2:0]  init_idx = '0;
    logic [90:0] init_centroid = '0;
    logic        new_valid = 1'b0;
    logic [90:0] new_centroid = '0;
    logic [2:0]  cent_cnt_nxt_block = '0;
    logic        divide_by_0 = 1'b0;
    logic [2:0]  rd_idx = '0;
    logic [90:0] rd_centroid;
    logic        iter_done;
    logic        converged;
    logic [7:0]  empty_mask;
    logic        dup_error;

    always #5 clk = ~clk;

    convergence_check_block dut (
        .clk                (clk),
        .rst                (rst),
        .start_iter         (start_iter),
        .threshold          (threshold),
        .init_load          (init_load),
        .init_idx           (init_idx),
        .init_centroid      (init_centroid),
        .new_valid          (new_valid),
        .new_centroid       (new_centroid),
        .cent_cnt_nxt_block (cent_cnt_nxt_block),
        .divide_by_0        (divide_by_0),
        .rd_idx             (rd_idx),
        .rd_centroid        (rd_centroid),
        .iter_done          (iter_done),
        .converged          (converged),
        .empty_mask         (empty_mask),
        .dup_error          (dup_error)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    logic [90:0] mdl [8];
    bit          got [8];
    bit          exp_moved;
    bit          exp_dup;
    logic [7:0]  exp_empty;
    int          mdl_thr;

    function automatic int crd(input logic [90:0] c, input int k);
        return int'(c[k*13 +: 13]);
    endfunction

    function automatic logic [90:0] set_crd(input logic [90:0] c, input int k, input int v);
        logic [90:0] r;
        r = c;
        r[k*13 +: 13] = 13'(v);
        return r;
    endfunction

    function automatic bit moves(input logic [90:0] o, input logic [90:0] n, input int t);
        for (int k = 0; k < 7; k++) begin
            int d;
            d = crd(n, k) - crd(o, k);
            if (d < 0) d = -d;
            if (d > t) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [90:0] rnd_cent();
        logic [90:0] c;
        c = '0;
        for (int k = 0; k < 7; k++) c = set_crd(c, k, int'($urandom_range(0, 8191)));
        return c;
    endfunction

    function automatic logic [90:0] nudge(input logic [90:0] c, input int maxd);
        logic [90:0] r;
        r = c;
        for (int k = 0; k < 7; k++) begin
            int v, d;
            v = crd(c, k);
            d = int'($urandom_range(0, maxd));
            if ((($urandom_range(0, 1) == 1) && (v + d <= 8191)) || (v - d < 0)) v = v + d;
            else v = v - d;
            r = set_crd(r, k, v);
        end
        return r;
    endfunction

    function automatic bit all_got();
        for (int i = 0; i < 8; i++) if (!got[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear_iter(input int t);
        mdl_thr   = t;
        exp_moved = 1'b0;
        exp_dup   = 1'b0;
        exp_empty = '0;
        for (int i = 0; i < 8; i++) got[i] = 1'b0;
    endtask

    // All stimulus tasks are entered and left on a falling edge.
    task automatic start(input int t);
        start_iter = 1'b1;
        threshold  = 13'(t);
        @(negedge clk);
        start_iter = 1'b0;
        model_clear_iter(t);
    endtask

    task automatic load(input int i, input logic [90:0] c);
        init_load     = 1'b1;
        init_idx      = 3'(i);
        init_centroid = c;
        @(negedge clk);
        init_load = 1'b0;
        mdl[i]    = c;
    endtask

    task automatic send(input int i, input logic [90:0] c, input bit dz, input bit live);
        new_valid          = 1'b1;
        cent_cnt_nxt_block = 3'(i);
        new_centroid       = c;
        divide_by_0        = dz;
        @(negedge clk);
        new_valid   = 1'b0;
        divide_by_0 = 1'b0;
        if (live) begin
            if (got[i]) exp_dup = 1'b1;
            got[i] = 1'b1;
            if (dz) exp_empty[i] = 1'b1;
            else begin
                if (moves(mdl[i], c, mdl_thr)) exp_moved = 1'b1;
                mdl[i] = c;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        n_tests++;
        if ({iter_done, converged, empty_mask, dup_error} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {iter_done, converged, empty_mask, dup_error});
        end
        rd_idx = 3'd6;
        #1;
        n_tests++;
        if (rd_centroid !== 91'd0) begin
            n_fail++;
            $display("FAIL reset_bank: got %h want 0", rd_centroid);
        end
    endtask

    task automatic test_init_load();
        for (int i = 0; i < 8; i++) load(i, 91'(i));
        rd_idx = 3'd3;
        #1;
        n_tests++;
        if (rd_centroid !== 91'd3) begin
            n_fail++;
            $display("FAIL init_read3: got %h want 3", rd_centroid);
        end
        @(negedge clk);
        start(5);
        for (int i = 0; i < 3; i++) send(i, rnd_cent(), 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({iter_done, converged, empty_mask, dup_error, rd_centroid} !== 102'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b %b %h %b %h want all 0", iter_done, converged, empty_mask, dup_error, rd_centroid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        for (int i = 0; i < 8; i++) load(i, rnd_cent());
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            n_tests++;
            if (rd_centroid !== mdl[i]) begin
                n_fail++;
                $display("FAIL init_bank[%0d]: got %h want %h", i, rd_centroid, mdl[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_not_converged();
        logic [90:0] c;
        start(4);
        for (int i = 0; i < 8; i++) begin
            c = nudge(mdl[i], 4);
            if (i == 5) c = set_crd(c, 2, (crd(mdl[5], 2) > 8181) ? crd(mdl[5], 2) - 10 : crd(mdl[5], 2) + 10);
            send(i, c, 1'b0, 1'b1);
            n_tests++;
            if (iter_done !== all_got()) begin
                n_fail++;
                $display("FAIL nc_iter_done beat%0d: got %b want %b", i, iter_done, all_got());
            end
        end
        n_tests++;
        if ({converged, empty_mask, dup_error} !== {~exp_moved, exp_empty, exp_dup} || exp_moved !== 1'b1) begin
            n_fail++;
            $display("FAIL nc_flags: got conv=%b empty=%h dup=%b want conv=0 empty=0 dup=0", converged, empty_mask, dup_error);
        end
        @(negedge clk);
        n_tests++;
        if (iter_done !== 1'b0) begin
            n_fail++;
            $display("FAIL nc_done_pulse: got %b want 0", iter_done);
        end
        rd_idx = 3'd5;
        #1;
        n_tests++;
        if (rd_centroid !== mdl[5]) begin
            n_fail++;
            $display("FAIL nc_bank5: got %h want %h", rd_centroid, mdl[5]);
        end
        @(negedge clk);
    endtask

    task automatic test_converged();
        logic [90:0] c;
        start(4);
        for (int i = 0; i < 8; i++) begin
            c = nudge(mdl[i], 4);
            if (i == 0) c = set_crd(c, 0, (crd(mdl[0], 0) >= 4) ? crd(mdl[0], 0) - 4 : crd(mdl[0], 0) + 4);
            send(i, c, 1'b0, 1'b1);
        end
        n_tests++;
        if (iter_done !== 1'b1 || converged !== ~exp_moved || exp_moved !== 1'b0) begin
            n_fail++;
            $display("FAIL conv_done: got done=%b conv=%b want done=1 conv=1", iter_done, converged);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (converged !== 1'b1 || iter_done !== 1'b0) begin
            n_fail++;
            $display("FAIL conv_held: got conv=%b done=%b want conv=1 done=0", converged, iter_done);
        end
    endtask

    task automatic test_empty_cluster();
        logic [90:0] old2;
        start(4);
        n_tests++;
        if (converged !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clears_conv: got %b want 0", converged);
        end
        old2 = mdl[2];
        for (int i = 0; i < 8; i++) begin
            if (i == 2) send(i, ~mdl[2], 1'b1, 1'b1);
            else send(i, nudge(mdl[i], 4), 1'b0, 1'b1);
        end
        n_tests++;
        if (empty_mask !== 8'h04 || converged !== 1'b1 || iter_done !== 1'b1) begin
            n_fail++;
            $display("FAIL empty: got mask=%h conv=%b done=%b want mask=04 conv=1 done=1", empty_mask, converged, iter_done);
        end
        rd_idx = 3'd2;
        #1;
        n_tests++;
        if (rd_centroid !== old2) begin
            n_fail++;
            $display("FAIL empty_bank2: got %h want %h", rd_centroid, old2);
        end
        @(negedge clk);
    endtask

    task automatic test_dup_out_of_order();
        int ord[9] = '{7, 0, 0, 1, 2, 3, 4, 5, 6};
        start(6);
        for (int b = 0; b < 9; b++) begin
            send(ord[b], nudge(mdl[ord[b]], 9), 1'b0, 1'b1);
            n_tests++;
            if (iter_done !== all_got()) begin
                n_fail++;
                $display("FAIL dup_iter_done beat%0d: got %b want %b", b, iter_done, all_got());
            end
        end
        n_tests++;
        if (dup_error !== 1'b1 || converged !== ~exp_moved) begin
            n_fail++;
            $display("FAIL dup_flags: got dup=%b conv=%b want dup=1 conv=%b", dup_error, converged, ~exp_moved);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(i, rnd_cent(), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            n_tests++;
            if (rd_centroid !== mdl[i]) begin
                n_fail++;
                $display("FAIL idle_beat_bank[%0d]: got %h want %h", i, rd_centroid, mdl[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_restart();
        int t;
        t = int'($urandom_range(0, 30));
        start(t);
        for (int i = 0; i < 4; i++) send(i, nudge(mdl[i], 20), 1'b0, 1'b1);
        t = int'($urandom_range(0, 30));
        start_iter         = 1'b1;
        threshold          = 13'(t);
        new_valid          = 1'b1;
        cent_cnt_nxt_block = 3'd5;
        new_centroid       = ~mdl[5];
        @(negedge clk);
        start_iter = 1'b0;
        new_valid  = 1'b0;
        model_clear_iter(t);
        rd_idx = 3'd5;
        #1;
        n_tests++;
        if (rd_centroid !== mdl[5]) begin
            n_fail++;
            $display("FAIL restart_dropped_beat: got %h want %h", rd_centroid, mdl[5]);
        end
        for (int i = 0; i < 8; i++) begin
            send(i, nudge(mdl[i], 20), 1'b0, 1'b1);
            n_tests++;
            if (iter_done !== all_got()) begin
                n_fail++;
                $display("FAIL restart_iter_done beat%0d: got %b want %b", i, iter_done, all_got());
            end
        end
        n_tests++;
        if (converged !== ~exp_moved || dup_error !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_flags: got conv=%b dup=%b want conv=%b dup=0", converged, dup_error, ~exp_moved);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int ord[$];
            int t, amp;
            bit ok;
            t   = (it == 0) ? 0 : (it == 1) ? 8191 : int'($urandom_range(0, 40));
            amp = int'($urandom_range(1, 50));
            ord = {0, 1, 2, 3, 4, 5, 6, 7};
            for (int i = 7; i > 0; i--) begin
                int j, tmp;
                j = int'($urandom_range(0, i));
                tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
            end
            if ($urandom_range(0, 2) == 0) begin
                int p;
                p = int'($urandom_range(0, 6));
                ord.insert(p + 1, ord[p]);
            end
            start(t);
            ok = 1'b1;
            foreach (ord[b]) begin
                logic [90:0] c;
                c = (it == 1) ? rnd_cent() : nudge(mdl[ord[b]], amp);
                send(ord[b], c, ($urandom_range(0, 7) == 0), 1'b1);
                if (iter_done !== all_got()) ok = 1'b0;
            end
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand%0d_iter_done: pulse timing wrong (final got %b want 1)", it, iter_done);
            end
            n_tests++;
            if ({converged, empty_mask, dup_error} !== {~exp_moved, exp_empty, exp_dup}) begin
                n_fail++;
                $display("FAIL rand%0d_flags thr=%0d: got conv=%b empty=%h dup=%b want conv=%b empty=%h dup=%b",
                         it, t, converged, empty_mask, dup_error, ~exp_moved, exp_empty, exp_dup);
            end
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                rd_idx = 3'(i);
                #1;
                n_tests++;
                if (rd_centroid !== mdl[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_bank[%0d]: got %h want %h", it, i, rd_centroid, mdl[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_init_load();
        test_not_converged();
        test_converged();
        test_empty_cluster();
        test_dup_out_of_order();
        test_restart();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/convergence_check_block.md
Name: convergence_check_block

Overview:
- Receiving end of the new-means divider interface.
- Accepts one new centroid per beat (7 coordinates × 13-bit fixed point, tagged with centroid index and divide-by-zero flag).
- Compares each new centroid with the stored previous centroid against a programmable threshold, then writes it into the centroid register bank.
- After all 8 centroids of an iteration arrive, reports iteration done and converged/not-converged to the controller. The bank is also read by the classification block.

Parameters:
- dataWidth, 91, packed centroid width (cord_num × cordinate_width)
- cordinate_width, 13, width of one fixed-point coordinate (unsigned)
- cord_num, 7, coordinates per centroid; coordinate k occupies bits [13k+12:13k], k=0 in LSBs
- centroid_num, 8, number of centroids in the bank
- idx_width, 3, centroid index width (log2 centroid_num)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start_iter  in  1  controller pulse; opens a collection window
- threshold  in  13  per-coordinate movement tolerance, unsigned; sampled when start_iter is seen
- init_load  in  1  write init_centroid to bank[init_idx]; honoured only in IDLE
- init_idx  in  3  index for init_load
- init_centroid  in  91  initial centroid data
- new_valid  in  1  divider beat valid (the divider's registered enable, one cycle after divider_en)
- new_centroid  in  91  divider result
- cent_cnt_nxt_block  in  3  index of new_centroid
- divide_by_0  in  1  divider saw count 0 (empty cluster)
- rd_idx  in  3  classification read index
- rd_centroid  out  91  bank[rd_idx], combinational read
- iter_done  out  1  one-cycle pulse: all 8 centroids received
- converged  out  1  valid from the iter_done cycle; held until the next start_iter
- empty_mask  out  8  bit i set if centroid i had divide_by_0 this iteration
- dup_error  out  1  sticky per iteration: an index arrived twice

Behaviour:
- Reset (async, rst=1):
  - bank cleared to 0; state IDLE.
  - iter_done=0, converged=0, empty_mask=0, dup_error=0; received mask=0, moved flag=0, threshold register=0.
- FSM states:
  - IDLE: init_load writes the bank (visible on rd_centroid next cycle). new_valid is ignored. start_iter → COLLECT; clears received mask, moved flag, empty_mask, dup_error, converged; captures threshold.
  - COLLECT: each new_valid beat is processed (see below). When the received mask becomes all-ones → DONE. start_iter here restarts the iteration (same clears, stays in COLLECT). init_load is ignored.
  - DONE: iter_done=1 for exactly this cycle; converged = !moved. Next state is IDLE unconditionally. A start_iter in DONE is taken on the following IDLE cycle only if it is reasserted.
- Beat processing (new_valid=1 in COLLECT, index i):
  - divide_by_0=1: bank[i] retains its old value; empty_mask[i]=1; no movement contributed.
  - divide_by_0=0: per coordinate k, d_k = |new_k − old_k| (14-bit unsigned difference, magnitude 13 bits). Movement if any d_k > threshold (strictly greater). moved |= movement. bank[i] ← new_centroid.
  - If mask[i] is already set: dup_error=1. Data is still written and the movement is still accumulated.
  - mask[i] set. All updates are registered at the clock edge after the beat.
- Latency: beat at cycle t → bank[i] and flags updated at t+1. If the beat completes the mask, state=DONE and iter_done=1 at t+1.
- Simultaneous events:
  - start_iter and new_valid in the same COLLECT cycle: start_iter wins and the beat is discarded.
  - init_load and start_iter in IDLE: both take effect.
- Threshold 0: any nonzero difference counts as movement. Threshold 8191: never moves.
- Reset mid-COLLECT: everything returns to reset values immediately; the partial iteration is lost.

Decomposition:
- kmeans_pkg holds CORD_WIDTH=13, CORD_NUM=7, CENT_NUM=8, DATA_WIDTH=91, IDX_WIDTH=3, a typedef for the packed centroid, and the state enum {IDLE, COLLECT, DONE}.
- Sub-module centroid_distance_cmp (combinational): inputs old/new 91-bit centroids and threshold; output moved. It holds the 7 absolute-difference comparators.

Test Plan:
1. Reset, then init_load bank[0..7]=0x0…i. Read rd_idx=3 → rd_centroid=3 the next cycle. Assert rst mid-way → all outputs 0.
2. Non-converged iteration: start_iter, threshold=4. Send 8 beats idx 0..7; idx 5 has coord2 +10 vs old → iter_done one cycle after the 8th beat, converged=0, bank[5] updated.
3. Converged iteration: threshold=4, all coordinate diffs ≤4 (including one exactly 4) → converged=1, held until the next start_iter.
4. Empty cluster: idx 2 with divide_by_0=1 and wildly different data → bank[2] unchanged, empty_mask=0x04, converged=1 if the others are within tolerance.
5. Duplicate and out-of-order indices: order 7,0,0,1..6 → dup_error=1, iter_done after 9 beats. Beats sent in IDLE are ignored (bank unchanged).
6. start_iter mid-COLLECT after 4 beats, coincident with a beat → that beat is dropped, mask cleared, and iter_done requires 8 fresh indices.
